// File: rtl/rom_lut_arbiter_pkg.sv
// Shared constants for the ROM LUT arbiter: bus widths and FSM state encodings.
package rom_lut_arbiter_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 2;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRead = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

endpackage

// File: rtl/rom_lut_arbiter_if.sv
// Request/acknowledge bus between the two requesters and the shared LUT arbiter.
interface rom_lut_arbiter_if;
  import rom_lut_arbiter_pkg::*;

  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              ack0;
  logic [DATA_W-1:0] data0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              ack1;
  logic [DATA_W-1:0] data1;
  logic              busy;
  logic              grant_id;

  // Requester side: drives requests, observes acks and data.
  modport master (
    output req0, addr0, req1, addr1,
    input  ack0, data0, ack1, data1, busy, grant_id
  );

  // Arbiter side.
  modport slave (
    input  req0, addr0, req1, addr1,
    output ack0, data0, ack1, data1, busy, grant_id
  );
endinterface

// File: rtl/rom_8x2.sv
// Fixed 8-word x 2-bit lookup ROM, addressed by {A, B, C} with A as the MSB.
module rom_8x2 (
  input  logic       A,
  input  logic       B,
  input  logic       C,
  output logic [1:0] Y
);

  // Purely combinational table lookup.
  always_comb begin
    Y = 2'b00;
    case ({A, B, C})
      3'd0: Y = 2'b10;
      3'd1: Y = 2'b11;
      3'd2: Y = 2'b00;
      3'd3: Y = 2'b00;
      3'd4: Y = 2'b11;
      3'd5: Y = 2'b11;
      3'd6: Y = 2'b00;
      3'd7: Y = 2'b10;
      default: Y = 2'b00;
    endcase
  end

endmodule

// File: rtl/rom_lut_arbiter.sv
// Round-robin arbiter sharing one rom_8x2 between two requesters.
// Each grant runs IDLE -> READ -> RESP, giving one read every three cycles.
module rom_lut_arbiter
  import rom_lut_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  rom_lut_arbiter_if.slave   bus
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] data0_q, data0_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rom_word;
  logic              pick;

  rom_8x2 u_rom (
    .A (addr_q[2]),
    .B (addr_q[1]),
    .C (addr_q[0]),
    .Y (rom_word)
  );

  // Next-state logic: arbitrate in IDLE, capture ROM word in READ, pulse ack in RESP.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    grant_d = grant_q;
    last_d  = last_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    data0_d = data0_q;
    data1_d = data1_q;
    // On a tie the requester that was not served last wins.
    pick    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          grant_d = pick;
          addr_d  = pick ? bus.addr1 : bus.addr0;
          state_d = StRead;
        end
      end
      StRead: begin
        if (grant_q) begin
          data1_d = rom_word;
          ack1_d  = 1'b1;
        end else begin
          data0_d = rom_word;
          ack0_d  = 1'b1;
        end
        last_d  = grant_q;
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      data0_q <= '0;
      data1_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.data0    = data0_q;
  assign bus.data1    = data1_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_q;

endmodule

// File: tb/tb_rom_lut_arbiter.sv
// Directed bench for rom_lut_arbiter: reset, latency, fairness, sweep, latch and abort cases.
module tb_rom_lut_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  rom_lut_arbiter_if bus ();

  rom_lut_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents indexed by address.
  logic [1:0] rom_exp [8];
  initial begin
    rom_exp[0] = 2'b10; rom_exp[1] = 2'b11; rom_exp[2] = 2'b00; rom_exp[3] = 2'b00;
    rom_exp[4] = 2'b11; rom_exp[5] = 2'b11; rom_exp[6] = 2'b00; rom_exp[7] = 2'b10;
  end

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One read from requester sel; checks busy, two-cycle latency, data and hold after ack.
  task automatic do_read(input logic sel, input logic [2:0] addr, input logic [1:0] exp);
    int lat;
    logic ack_s;
    lat = 0;
    @(negedge clk);
    if (sel) begin bus.req1 = 1'b1; bus.addr1 = addr; end
    else     begin bus.req0 = 1'b1; bus.addr0 = addr; end
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      ack_s = sel ? bus.ack1 : bus.ack0;
      if (i == 1) check_eq("busy_read", {7'd0, bus.busy}, 8'd1);
      if (ack_s) begin
        lat = i;
        check_eq("busy_resp", {7'd0, bus.busy}, 8'd1);
        check_eq("other_ack", {7'd0, sel ? bus.ack0 : bus.ack1}, 8'd0);
        break;
      end
    end
    check_eq("latency", lat[7:0], 8'd2);
    check_eq("data", {6'd0, sel ? bus.data1 : bus.data0}, {6'd0, exp});
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    check_eq("data_hold", {6'd0, sel ? bus.data1 : bus.data0}, {6'd0, exp});
    check_eq("ack_gone", {6'd0, bus.ack0, bus.ack1}, 8'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    bus.req0 = 1'b0; bus.addr0 = '0;
    bus.req1 = 1'b0; bus.addr1 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset then idle: {ack0, ack1, data0, data1, busy, grant_id} all zero.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("idle_state", {bus.ack0, bus.ack1, bus.data0, bus.data1, bus.busy, bus.grant_id},
               8'd0);
    end

    // Single read.
    do_read(1'b0, 3'd1, 2'b11);

    // Tie: fresh reset so requester 0 wins first; expect ack0 @2,8 and ack1 @5,11.
    apply_reset();
    @(negedge clk);
    bus.req0 = 1'b1; bus.addr0 = 3'd4;
    bus.req1 = 1'b1; bus.addr1 = 3'd7;
    for (int i = 1; i <= 11; i++) begin
      logic [1:0] exp_acks;
      @(negedge clk);
      exp_acks = {(i == 2 || i == 8), (i == 5 || i == 11)};
      check_eq("tie_acks", {6'd0, bus.ack0, bus.ack1}, {6'd0, exp_acks});
      if (i == 2) check_eq("tie_data0", {6'd0, bus.data0}, 8'h03);
      if (i == 5) check_eq("tie_data1", {6'd0, bus.data1}, 8'h02);
      if (i == 3) check_eq("tie_grant1", {7'd0, bus.grant_id}, 8'd0);
      if (i == 4) check_eq("tie_grant2", {7'd0, bus.grant_id}, 8'd1);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);

    // Full sweep from requester 1.
    for (int a = 0; a < 8; a++) begin
      logic [2:0] av;
      av = a[2:0];
      do_read(1'b1, av, rom_exp[a]);
    end

    // Address change after the grant edge is ignored.
    @(negedge clk);
    bus.req0 = 1'b1; bus.addr0 = 3'd0;
    @(negedge clk);
    bus.addr0 = 3'd2;
    @(negedge clk);
    check_eq("latch_ack", {7'd0, bus.ack0}, 8'd1);
    check_eq("latch_data", {6'd0, bus.data0}, 8'h02);
    bus.req0 = 1'b0;
    @(negedge clk);

    // Reset during READ for requester 1: no ack, data cleared.
    @(negedge clk);
    bus.req1 = 1'b1; bus.addr1 = 3'd1;
    @(negedge clk);
    reset = 1'b1;
    bus.req1 = 1'b0;
    @(negedge clk);
    check_eq("abort_state", {bus.ack0, bus.ack1, bus.data0, bus.data1, bus.busy, bus.grant_id},
             8'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("abort_noack", {5'd0, bus.ack1, bus.data1}, 8'd0);
    end
    do_read(1'b1, 3'd5, 2'b11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/rom_lut_arbiter.md
Name: rom_lut_arbiter

Overview:
- Round-robin arbiter and read sequencer that shares one 8x2 lookup ROM (rom_8x2) between two requesters.
- Each requester presents a 3-bit address with a req/ack handshake and receives the registered 2-bit ROM word.
- Sits between the lab's control blocks and the shared LUT, so each requester does not need its own ROM copy.

Parameters:
- ADDR_W, 3, address width; fixed by rom_8x2 depth (8 words).
- DATA_W, 2, data width; fixed by rom_8x2 word size.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 read request; held high until ack0.
- addr0  input  3  requester 0 address; stable while req0 is high.
- ack0  output  1  one-cycle pulse; data0 is valid in this cycle.
- data0  output  2  registered ROM word for requester 0; updated only with ack0, held otherwise.
- req1  input  1  requester 1 read request; same rules as req0.
- addr1  input  3  requester 1 address.
- ack1  output  1  requester 1 ack pulse.
- data1  output  2  requester 1 registered ROM word.
- busy  output  1  high while state is not IDLE.
- grant_id  output  1  requester currently being served; holds the last value in IDLE.

Behaviour:
- Reset (async, active-high): state=IDLE, ack0=ack1=0, data0=data1=2'b00, busy=0, grant_id=0, last_served=1, so requester 0 wins the first tie.
- FSM states are IDLE, READ and RESP. State and all outputs are registered.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant it.
  - Both req: grant the requester != last_served.
  - On grant: latch the address into addr_q, set grant_id, go to READ.
- READ:
  - addr_q drives the rom_8x2 inputs: A=addr_q[2], B=addr_q[1], C=addr_q[0].
  - Capture the ROM output into the data register of the granted requester.
  - Assert that requester's ack on the next edge, update last_served=grant_id, go to RESP.
- RESP:
  - ack for grant_id is high for exactly this one cycle; the other ack is 0.
  - Next state is always IDLE (one mandatory idle cycle).
- Latency: req sampled high in IDLE at edge N; ack high during cycle N+2. Throughput is one read per 3 cycles.
- Both acks are never high together, and there is never more than one ack per grant.
- req still high in the cycle after ack: treated as a new request and arbitrated normally in IDLE.
- Starvation-free: with both reqs permanently high, grants alternate 0,1,0,1.
- req dropped before ack: protocol violation. The transaction still completes and ack is still pulsed.
- addr change while req is high: ignored after the IDLE grant edge, because addr_q is latched.
- Reset asserted mid-transaction: abort immediately, no ack for the pending read, data registers cleared to 00.
- ROM contents (addr: word): 0:10, 1:11, 2:00, 3:00, 4:11, 5:11, 6:00, 7:10.

Decomposition:
- Shared package/header: state encodings IDLE=2'd0, READ=2'd1, RESP=2'd2; ADDR_W and DATA_W constants.
- One sub-module: the existing rom_8x2, instantiated unchanged as the shared resource. It is not duplicated.
- Arbitration (last_served pointer) and the FSM stay inline in rom_lut_arbiter.

Test Plan:
- Reset then idle: reset pulse, no reqs for 5 cycles -> ack0=ack1=0, data0=data1=00, busy=0, grant_id=0.
- Single read: req0=1, addr0=3'd1 at edge N -> ack0=1 in cycle N+2 with data0=2'b11; busy=1 during N+1..N+2; req0 dropped -> data0 holds 11.
- Tie and fairness: req0=req1=1, addr0=4, addr1=7, both held -> grant order 0,1,0,1; ack0 with data0=11, ack1 with data1=10, 3 cycles apart; acks never overlap.
- Full address sweep from requester 1: addr1=0..7 sequentially -> data1 = 10,11,00,00,11,11,00,10.
- Address change after grant: req0 with addr0=0, switched to addr0=2 one cycle after the grant -> data0=10 (the latched address 0 wins).
- Reset mid-operation: assert reset during READ for requester 1 -> ack1 never pulses, data1=00, state IDLE; after release, req1 with addr1=5 -> ack1 with data1=11.
